ram_sp_rwmode: RTL and testbench

- Single-port synchronous RAM with per-byte write enables.
- Read-during-write behaviour is selectable at elaboration time: write-first, read-first or no-change.
- An optional output pipeline register is available.
- Generalised successor of the team's fixed write-first RAM; used as the common storage primitive for buffers and register files in the design.

---
 rtl/ram_sp_rwmode_if.sv | 18 +
 rtl/ram_sp_rwmode.sv | 90 +++++++++
 tb/tb_ram_sp_rwmode.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ram_sp_rwmode_if.sv
// Bus bundle for the single-port RAM: access request from the master, read result back from the RAM.
interface ram_sp_rwmode_if #(
  parameter int addressWidth = 5,
  parameter int dataWidth    = 32,
  parameter int byteWidth    = 8
);
  localparam int NB = dataWidth / byteWidth;

  logic                    en;
  logic [NB-1:0]           we;
  logic [addressWidth-1:0] address;
  logic [dataWidth-1:0]    din;
  logic [dataWidth-1:0]    dout;
  logic                    dout_valid;

  modport master (output en, we, address, din, input dout, dout_valid);
  modport slave  (input en, we, address, din, output dout, dout_valid);
endinterface

// File: rtl/ram_sp_rwmode.sv
// Single-port synchronous RAM with byte-lane write enables, elaboration-selectable
// read-during-write behaviour and an optional output register.
module ram_sp_rwmode #(
  parameter int addressWidth = 5,
  parameter int dataWidth    = 32,
  parameter int byteWidth    = 8,
  parameter int rwMode       = 0,
  parameter int outReg       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_sp_rwmode_if.slave    bus
);
  localparam int NB    = dataWidth / byteWidth;
  localparam int DEPTH = 2 ** addressWidth;

  if (dataWidth % byteWidth != 0) begin : g_bad_width
    $error("ram_sp_rwmode: dataWidth must be a multiple of byteWidth");
  end
  if (rwMode < 0 || rwMode > 2) begin : g_bad_mode
    $error("ram_sp_rwmode: rwMode must be 0, 1 or 2");
  end
  if (outReg < 0 || outReg > 1) begin : g_bad_outreg
    $error("ram_sp_rwmode: outReg must be 0 or 1");
  end

  logic [dataWidth-1:0] mem [DEPTH];
  logic [dataWidth-1:0] rd_word;
  logic [dataWidth-1:0] merged;
  logic [dataWidth-1:0] s1_data;
  logic                 s1_valid;

  // merged is the word as it will look after this cycle's write
  always_comb begin
    rd_word = mem[bus.address];
    merged  = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (bus.we[i]) merged[i*byteWidth +: byteWidth] = bus.din[i*byteWidth +: byteWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && bus.en) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.we[i]) mem[bus.address][i*byteWidth +: byteWidth] <= bus.din[i*byteWidth +: byteWidth];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else if (!bus.en) begin
      s1_valid <= 1'b0;
    end else if (bus.we == '0) begin
      s1_data  <= rd_word;
      s1_valid <= 1'b1;
    end else if (rwMode == 0) begin
      s1_data  <= merged;
      s1_valid <= 1'b1;
    end else if (rwMode == 1) begin
      s1_data  <= rd_word;
      s1_valid <= 1'b1;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  if (outReg == 1) begin : g_out_reg
    logic [dataWidth-1:0] s2_data;
    logic                 s2_valid;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_data  <= s1_data;
        s2_valid <= s1_valid;
      end
    end

    assign bus.dout       = s2_data;
    assign bus.dout_valid = s2_valid;
  end else begin : g_out_direct
    assign bus.dout       = s1_data;
    assign bus.dout_valid = s1_valid;
  end
endmodule

// File: tb/tb_ram_sp_rwmode.sv
// Directed bench: four RAM variants (write-first, read-first, no-change, write-first with
// output register) share one stimulus stream and are checked against hand-computed values.
module tb_ram_sp_rwmode;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_sp_rwmode_if #(.addressWidth(5), .dataWidth(32), .byteWidth(8)) bus_wf ();
  ram_sp_rwmode_if #(.addressWidth(5), .dataWidth(32), .byteWidth(8)) bus_rf ();
  ram_sp_rwmode_if #(.addressWidth(5), .dataWidth(32), .byteWidth(8)) bus_nc ();
  ram_sp_rwmode_if #(.addressWidth(5), .dataWidth(32), .byteWidth(8)) bus_wr ();

  ram_sp_rwmode #(.rwMode(0), .outReg(0)) u_wf (.clk(clk), .rst_n(rst_n), .bus(bus_wf));
  ram_sp_rwmode #(.rwMode(1), .outReg(0)) u_rf (.clk(clk), .rst_n(rst_n), .bus(bus_rf));
  ram_sp_rwmode #(.rwMode(2), .outReg(0)) u_nc (.clk(clk), .rst_n(rst_n), .bus(bus_nc));
  ram_sp_rwmode #(.rwMode(0), .outReg(1)) u_wr (.clk(clk), .rst_n(rst_n), .bus(bus_wr));

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] wf_d;
    logic        wf_v;
    logic [31:0] rf_d;
    logic        rf_v;
    logic        rf_dc;   // read-first returns a never-written word here
    logic [31:0] nc_d;
    logic        nc_v;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] w,
                              input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] wfd, input logic wfv,
                              input logic [31:0] rfd, input logic rfv, input logic rfdc,
                              input logic [31:0] ncd, input logic ncv);
    vec_t v;
    v.rst_n = r;  v.en = e;  v.we = w;  v.addr = a;  v.din = d;
    v.wf_d = wfd; v.wf_v = wfv;
    v.rf_d = rfd; v.rf_v = rfv; v.rf_dc = rfdc;
    v.nc_d = ncd; v.nc_v = ncv;
    return v;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [3:0] w,
                       input logic [4:0] a, input logic [31:0] d);
    rst_n = r;
    bus_wf.en = e; bus_wf.we = w; bus_wf.address = a; bus_wf.din = d;
    bus_rf.en = e; bus_rf.we = w; bus_rf.address = a; bus_rf.din = d;
    bus_nc.en = e; bus_nc.we = w; bus_nc.address = a; bus_nc.din = d;
    bus_wr.en = e; bus_wr.we = w; bus_wr.address = a; bus_wr.din = d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst en  we     a   din           wf_d          v  rf_d          v  dc  nc_d          v
    tbl[0]  = mk(0, 1, 4'hF, 3, 32'hDEADBEEF, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    tbl[1]  = mk(0, 1, 4'hF, 3, 32'hDEADBEEF, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    tbl[2]  = mk(1, 1, 4'hF, 3, 32'h0,        32'h0,        1, 32'h0,        1, 1, 32'h0,        0);
    tbl[3]  = mk(1, 1, 4'h0, 3, 32'h0,        32'h0,        1, 32'h0,        1, 0, 32'h0,        1);
    tbl[4]  = mk(1, 1, 4'hF, 1, 32'h11223344, 32'h11223344, 1, 32'h0,        1, 1, 32'h0,        0);
    tbl[5]  = mk(1, 1, 4'h3, 1, 32'hAAAABBBB, 32'h1122BBBB, 1, 32'h11223344, 1, 0, 32'h0,        0);
    tbl[6]  = mk(1, 1, 4'h0, 1, 32'h0,        32'h1122BBBB, 1, 32'h1122BBBB, 1, 0, 32'h1122BBBB, 1);
    tbl[7]  = mk(1, 1, 4'hF, 2, 32'h5,        32'h5,        1, 32'h0,        1, 1, 32'h1122BBBB, 0);
    tbl[8]  = mk(1, 1, 4'h0, 2, 32'h0,        32'h5,        1, 32'h5,        1, 0, 32'h5,        1);
    tbl[9]  = mk(1, 1, 4'hF, 2, 32'h9,        32'h9,        1, 32'h5,        1, 0, 32'h5,        0);
    tbl[10] = mk(1, 1, 4'h0, 2, 32'h0,        32'h9,        1, 32'h9,        1, 0, 32'h9,        1);
    tbl[11] = mk(1, 0, 4'hF, 2, 32'hFFFFFFFF, 32'h9,        0, 32'h9,        0, 0, 32'h9,        0);
    tbl[12] = mk(1, 1, 4'h0, 2, 32'h0,        32'h9,        1, 32'h9,        1, 0, 32'h9,        1);
    tbl[13] = mk(1, 1, 4'hC, 1, 32'hCCDD0000, 32'hCCDDBBBB, 1, 32'h1122BBBB, 1, 0, 32'h9,        0);
    tbl[14] = mk(1, 1, 4'hF, 0, 32'hCAFE0001, 32'hCAFE0001, 1, 32'h0,        1, 1, 32'h9,        0);
    tbl[15] = mk(1, 1, 4'h0, 1, 32'hFFFFFFFF, 32'hCCDDBBBB, 1, 32'hCCDDBBBB, 1, 0, 32'hCCDDBBBB, 1);
    tbl[16] = mk(0, 1, 4'hF, 1, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h0,        0);
    tbl[17] = mk(1, 1, 4'h0, 1, 32'h0,        32'hCCDDBBBB, 1, 32'hCCDDBBBB, 1, 0, 32'hCCDDBBBB, 1);

    for (int k = 0; k < NV; k++) begin
      logic [31:0] wr_d;
      logic        wr_v;
      drive(tbl[k].rst_n, tbl[k].en, tbl[k].we, tbl[k].addr, tbl[k].din);
      step();
      check($sformatf("wf_dout[%0d]", k), bus_wf.dout, tbl[k].wf_d);
      check($sformatf("wf_valid[%0d]", k), {31'b0, bus_wf.dout_valid}, {31'b0, tbl[k].wf_v});
      if (!tbl[k].rf_dc) check($sformatf("rf_dout[%0d]", k), bus_rf.dout, tbl[k].rf_d);
      check($sformatf("rf_valid[%0d]", k), {31'b0, bus_rf.dout_valid}, {31'b0, tbl[k].rf_v});
      check($sformatf("nc_dout[%0d]", k), bus_nc.dout, tbl[k].nc_d);
      check($sformatf("nc_valid[%0d]", k), {31'b0, bus_nc.dout_valid}, {31'b0, tbl[k].nc_v});
      // registered variant lags the write-first stage 1 by one edge; reset clears it
      if (k == 0 || !tbl[k].rst_n) begin
        wr_d = 32'h0;
        wr_v = 1'b0;
      end else begin
        wr_d = tbl[k-1].wf_d;
        wr_v = tbl[k-1].wf_v;
      end
      check($sformatf("wr_dout[%0d]", k), bus_wr.dout, wr_d);
      check($sformatf("wr_valid[%0d]", k), {31'b0, bus_wr.dout_valid}, {31'b0, wr_v});
    end

    // output-register latency: one read, then the port goes idle
    drive(1, 0, 4'h0, 0, 32'h0);
    step();
    step();
    drive(1, 1, 4'h0, 0, 32'h0);
    step();
    check("lat_valid_t1", {31'b0, bus_wr.dout_valid}, 32'h0);
    check("lat_wf_t1", bus_wf.dout, 32'hCAFE0001);
    drive(1, 0, 4'h0, 0, 32'h0);
    step();
    check("lat_valid_t2", {31'b0, bus_wr.dout_valid}, 32'h1);
    check("lat_dout_t2", bus_wr.dout, 32'hCAFE0001);
    check("lat_wf_hold", bus_wf.dout, 32'hCAFE0001);
    check("lat_wf_valid_drop", {31'b0, bus_wf.dout_valid}, 32'h0);
    step();
    check("lat_valid_t3", {31'b0, bus_wr.dout_valid}, 32'h0);
    check("lat_dout_hold", bus_wr.dout, 32'hCAFE0001);

    // streaming: fill every word, then read it back with en held high
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 4'hF, i[4:0], i * 3);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 4'h0, i[4:0], 32'h0);
      step();
      check($sformatf("str_wf[%0d]", i), bus_wf.dout, i * 3);
      check($sformatf("str_rf[%0d]", i), bus_rf.dout, i * 3);
      check($sformatf("str_nc[%0d]", i), bus_nc.dout, i * 3);
      check($sformatf("str_v[%0d]", i),
            {29'b0, bus_wf.dout_valid, bus_rf.dout_valid, bus_nc.dout_valid}, 32'h7);
      if (i > 0) begin
        check($sformatf("str_wr[%0d]", i), bus_wr.dout, (i - 1) * 3);
        check($sformatf("str_wr_v[%0d]", i), {31'b0, bus_wr.dout_valid}, 32'h1);
      end
    end
    drive(1, 0, 4'h0, 0, 32'h0);
    step();
    check("str_wr_last", bus_wr.dout, 32'd93);
    check("str_wr_last_v", {31'b0, bus_wr.dout_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
